instruction_memory_responder: RTL and testbench

INSTRUCTION_MEMORY_RESPONDER -- requirements
Module: instruction_memory_responder

---
 rtl/instruction_memory_responder.sv | 116 +++++++++++
 tb/tb_instruction_memory_responder.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_memory_responder.sv
// Instruction memory responder: single-clock word store with a program-load
// port and a valid/ready fetch port that can insert configurable wait states.
module instruction_memory_responder #(
  parameter int unsigned MEMORY_WIDTH      = 16,
  parameter int unsigned MEMORY_ADDR_WIDTH = 11,
  parameter int unsigned WAIT_STATES       = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         memory_valid,
  input  logic [MEMORY_ADDR_WIDTH-1:0] memory_addr,
  output logic                         memory_ready,
  output logic [MEMORY_WIDTH-1:0]      memory_data,
  input  logic                         load_en,
  input  logic [MEMORY_ADDR_WIDTH-1:0] load_addr,
  input  logic [MEMORY_WIDTH-1:0]      load_data,
  output logic                         busy,
  output logic [31:0]                  fetch_count
);

  localparam int unsigned DEPTH = 2 ** MEMORY_ADDR_WIDTH;
  localparam int unsigned CNT_W = 4;
  // Wait counter preload; unused when no wait states are configured.
  localparam logic [CNT_W-1:0] WAIT_LOAD =
    (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GRANT = 2'd2,
    DATA  = 2'd3
  } state_t;

  state_t                  state;
  logic [CNT_W-1:0]        wait_cnt;
  logic                    data_vld;
  logic                    rd_en;
  logic [MEMORY_WIDTH-1:0] rd_word;
  logic [MEMORY_WIDTH-1:0] mem [DEPTH];

  // A fetch is accepted when the grant strobe meets a live request.
  assign rd_en = memory_ready && memory_valid;

  // Read word is hidden until the first accepted fetch after reset.
  assign memory_data = data_vld ? rd_word : '0;

  // Fetch sequencer; ready and busy are registered alongside the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      wait_cnt     <= '0;
      memory_ready <= 1'b0;
      busy         <= 1'b0;
      fetch_count  <= '0;
      data_vld     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (memory_valid && !load_en) begin
            busy <= 1'b1;
            if (WAIT_STATES == 0) begin
              state        <= GRANT;
              memory_ready <= 1'b1;
            end else begin
              state    <= WAIT;
              wait_cnt <= WAIT_LOAD;
            end
          end
        end
        WAIT: begin
          if (!memory_valid) begin
            state    <= IDLE;
            busy     <= 1'b0;
            wait_cnt <= '0;
          end else if (wait_cnt == '0) begin
            state        <= GRANT;
            memory_ready <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        GRANT: begin
          memory_ready <= 1'b0;
          if (memory_valid) begin
            state    <= DATA;
            data_vld <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        DATA: begin
          fetch_count <= fetch_count + 32'd1;
          state       <= IDLE;
          busy        <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          memory_ready <= 1'b0;
          busy         <= 1'b0;
        end
      endcase
    end
  end

  // Block-RAM style storage: write port plus registered read, old data on collision.
  always_ff @(posedge clk) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
    if (rd_en) begin
      rd_word <= mem[memory_addr];
    end
  end

endmodule

// File: tb/tb_instruction_memory_responder.sv
// Scoreboard bench for instruction_memory_responder with 0, 3 and 5 wait states.
module tb_instruction_memory_responder;

  typedef struct {
    int          k;
    logic [15:0] w;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        vld [3];
  logic [10:0] adr [3];
  logic        rdy [3];
  logic [15:0] dat [3];
  logic        bsy [3];
  logic [31:0] cnt [3];
  logic        load_en;
  logic [10:0] load_addr;
  logic [15:0] load_data;

  int   n_cmp;
  int   n_err;
  int   cyc;
  int   grants [3];
  bit   pend [3];
  bit   prev_rdy [3];
  exp_t sb [$];

  instruction_memory_responder #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst), .memory_valid(vld[0]), .memory_addr(adr[0]),
    .memory_ready(rdy[0]), .memory_data(dat[0]), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .busy(bsy[0]), .fetch_count(cnt[0]));

  instruction_memory_responder #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst), .memory_valid(vld[1]), .memory_addr(adr[1]),
    .memory_ready(rdy[1]), .memory_data(dat[1]), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .busy(bsy[1]), .fetch_count(cnt[1]));

  instruction_memory_responder #(.WAIT_STATES(5)) u_ws5 (
    .clk(clk), .rst(rst), .memory_valid(vld[2]), .memory_addr(adr[2]),
    .memory_ready(rdy[2]), .memory_data(dat[2]), .load_en(load_en),
    .load_addr(load_addr), .load_data(load_data), .busy(bsy[2]), .fetch_count(cnt[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Output monitor: pops the scoreboard in the cycle after each accepted grant.
  initial begin
    exp_t e;
    for (int k = 0; k < 3; k++) begin
      grants[k] = 0; pend[k] = 0; prev_rdy[k] = 0;
    end
    forever begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        if (pend[k]) begin
          pend[k] = 0;
          if (sb.size() == 0) begin
            check_eq("sb_underflow", 32'd1, 32'd0);
          end else begin
            e = sb.pop_front();
            check_eq("data_dut", 32'(k), 32'(e.k));
            check_eq("data_word", 32'(dat[k]), 32'(e.w));
          end
        end
        if (rdy[k] === 1'b1) begin
          grants[k]++;
          check_eq("ready_twice", 32'(prev_rdy[k]), 32'd0);
          if (vld[k]) pend[k] = 1;
        end
        prev_rdy[k] = (rdy[k] === 1'b1);
      end
    end
  end

  task automatic load_word(input logic [10:0] a, input logic [15:0] w);
    @(posedge clk); #1;
    load_en = 1'b1; load_addr = a; load_data = w;
    @(posedge clk); #1;
    load_en = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) vld[k] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic wait_grant(input int k, output bit got);
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(negedge clk);
      if (rdy[k] === 1'b1) got = 1;
    end
    check_eq("grant_seen", 32'(got), 32'd1);
  endtask

  task automatic fetch_one(input int k, input logic [10:0] a, input logic [15:0] w, input int lat);
    int n;
    bit got;
    @(posedge clk); #1;
    vld[k] = 1'b1; adr[k] = a;
    sb.push_back('{k: k, w: w});
    n = cyc;
    wait_grant(k, got);
    if (got) check_eq("grant_latency", 32'(cyc - n), 32'(lat));
    @(posedge clk); #1;
    vld[k] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int  n;
    int  last;
    int  g0;
    bit  got;
    logic [31:0] c0;
    n_cmp = 0; n_err = 0;
    rst = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
    for (int k = 0; k < 3; k++) begin vld[k] = 1'b0; adr[k] = '0; end

    // Reset state
    repeat (3) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_eq("rst_ready", 32'(rdy[k]), 32'd0);
      check_eq("rst_busy", 32'(bsy[k]), 32'd0);
      check_eq("rst_data", 32'(dat[k]), 32'd0);
      check_eq("rst_count", cnt[k], 32'd0);
    end
    @(posedge clk); #1 rst = 1'b1;

    // Program image shared by all three instances
    load_word(11'd245, 16'h00DC);
    for (int i = 0; i < 5; i++) load_word(11'(i), 16'h1000 + 16'(i));
    load_word(11'd50, 16'h1111);
    load_word(11'd100, 16'hBEEF);
    load_word(11'h7FF, 16'hA5A5);

    // Single fetch, no wait states
    fetch_one(0, 11'd245, 16'h00DC, 1);
    check_eq("count_one", cnt[0], 32'd1);
    repeat (3) @(posedge clk);
    #1 check_eq("data_hold", 32'(dat[0]), 32'h00DC);
    check_eq("busy_idle", 32'(bsy[0]), 32'd0);

    // Three wait states, then top-of-memory address
    fetch_one(1, 11'd1, 16'h1001, 4);
    fetch_one(1, 11'h7FF, 16'hA5A5, 4);
    check_eq("count_ws3", cnt[1], 32'd2);

    // Back-to-back fetches with valid held high
    do_reset();
    @(posedge clk); #1;
    vld[0] = 1'b1; adr[0] = 11'd0;
    sb.push_back('{k: 0, w: 16'h1000});
    n = cyc; last = 0;
    for (int i = 0; i < 5; i++) begin
      wait_grant(0, got);
      if (i == 0) check_eq("b2b_first_latency", 32'(cyc - n), 32'd1);
      else        check_eq("b2b_spacing", 32'(cyc - last), 32'd3);
      last = cyc;
      @(posedge clk); #1;
      if (i < 4) begin
        adr[0] = 11'(i + 1);
        sb.push_back('{k: 0, w: 16'h1000 + 16'(i + 1)});
      end else begin
        vld[0] = 1'b0;
      end
    end
    repeat (3) @(posedge clk);
    #1 check_eq("b2b_count", cnt[0], 32'd5);

    // Grant offered but request withdrawn: no fetch counted
    c0 = cnt[0];
    @(posedge clk); #1 vld[0] = 1'b1; adr[0] = 11'd2;
    @(posedge clk); #1 vld[0] = 1'b0;
    @(negedge clk) check_eq("grant_no_valid", 32'(rdy[0]), 32'd1);
    repeat (3) @(posedge clk);
    #1 check_eq("withdrawn_count", cnt[0], c0);
    check_eq("withdrawn_busy", 32'(bsy[0]), 32'd0);

    // Load priority holds off a pending request
    do_reset();
    @(posedge clk); #1;
    load_en = 1'b1; load_addr = 11'd50; load_data = 16'h2222;
    vld[0] = 1'b1; adr[0] = 11'd50;
    sb.push_back('{k: 0, w: 16'h2222});
    for (int j = 0; j < 4; j++) begin
      @(negedge clk) check_eq("ready_in_load", 32'(rdy[0]), 32'd0);
    end
    @(posedge clk); #1 load_en = 1'b0;
    n = cyc;
    wait_grant(0, got);
    if (got) check_eq("load_grant_latency", 32'(cyc - n), 32'd1);
    @(posedge clk); #1 vld[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 check_eq("load_count", cnt[0], 32'd1);

    // Write colliding with the read of the same address returns the old word
    @(posedge clk); #1 vld[0] = 1'b1; adr[0] = 11'd3;
    sb.push_back('{k: 0, w: 16'h1003});
    wait_grant(0, got);
    load_en = 1'b1; load_addr = 11'd3; load_data = 16'h3333;
    @(posedge clk); #1 load_en = 1'b0; vld[0] = 1'b0;
    repeat (2) @(posedge clk);
    fetch_one(0, 11'd3, 16'h3333, 1);

    // Reset during WAIT aborts the fetch, memory retained
    do_reset();
    g0 = grants[2];
    @(posedge clk); #1 vld[2] = 1'b1; adr[2] = 11'd100;
    repeat (2) @(posedge clk);
    #1 check_eq("busy_in_wait", 32'(bsy[2]), 32'd1);
    rst = 1'b0;
    #1 check_eq("abort_ready", 32'(rdy[2]), 32'd0);
    check_eq("abort_busy", 32'(bsy[2]), 32'd0);
    check_eq("abort_count", cnt[2], 32'd0);
    vld[2] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (8) @(posedge clk);
    #1 check_eq("abort_no_grant", 32'(grants[2] - g0), 32'd0);
    check_eq("abort_count_after", cnt[2], 32'd0);
    fetch_one(2, 11'd100, 16'hBEEF, 6);
    check_eq("ws5_count", cnt[2], 32'd1);

    // Fetch counter wraps
    force u_ws0.fetch_count = 32'hFFFF_FFFF;
    #1 release u_ws0.fetch_count;
    #1 check_eq("count_forced", cnt[0], 32'hFFFF_FFFF);
    fetch_one(0, 11'd4, 16'h1004, 1);
    check_eq("count_wrap", cnt[0], 32'd0);

    repeat (2) @(posedge clk);
    #1 check_eq("sb_drained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
